// File: rtl/fifo4x16.sv
// fifo4x16: four-entry, 16-bit show-ahead FIFO with occupancy, full/empty
// status and one-cycle overflow/underflow pulses for rejected requests.
module fifo4x16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic [2:0]       count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [1:0]       wp_r;
  logic [1:0]       rp_r;
  logic [2:0]       count_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status flags come from the occupancy counter, never from pointer compare.
  assign full_s  = (count_r == 3'(DEPTH));
  assign empty_s = (count_r == 3'd0);

  // A push into a full FIFO is still legal when a pop vacates the same slot.
  assign push_ok_s = push && (!full_s || pop);
  assign pop_ok_s  = pop && !empty_s;

  // Storage, pointers, occupancy and error pulses; pointers wrap at 2 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wp_r        <= 2'd0;
      rp_r        <= 2'd0;
      count_r     <= 3'd0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wp_r] <= in;
        wp_r        <= wp_r + 2'd1;
      end
      if (pop_ok_s) begin
        rp_r <= rp_r + 2'd1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
      overflow_r  <= push && !push_ok_s;
      underflow_r <= pop && !pop_ok_s;
    end
  end

  // Show-ahead read port: oldest word, or zero while nothing is stored.
  always_comb begin
    out = {WIDTH{1'b0}};
    if (!empty_s) begin
      out = mem_r[rp_r];
    end else begin
      out = {WIDTH{1'b0}};
    end
  end

  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule
